// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the g_core 16-bit processor.
// Optional feature macro CORE_SEQ_TRAP_EN: opcodes 5-15 halt the core instead of executing as NOP.
module core_seq #(
  parameter int PC_W = 12,
  parameter int DW   = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_pc,
  input  logic            i_imem_ack,
  input  logic [15:0]     i_imem_data,
  output logic [15:0]     o_ir,
  input  logic [3:0]      i_op,
  input  logic            i_lw,
  input  logic            i_j,
  input  logic            i_br,
  input  logic            i_bq_blt,
  input  logic [4:0]      i_src,
  input  logic [4:0]      i_dst,
  input  logic [15:0]     i_imm,
  input  logic [DW-1:0]   i_src_val,
  input  logic [DW-1:0]   i_dst_val,
  input  logic [DW-1:0]   i_tgt_val,
  output logic            o_dmem_req,
  output logic [DW-1:0]   o_dmem_addr,
  input  logic            i_dmem_ack,
  input  logic [DW-1:0]   i_dmem_data,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [DW-1:0]   o_rf_wdata,
  output logic            o_retire,
  output logic            o_trap,
  output logic [2:0]      o_dbg_state
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Handshake: a request stays high until its ack is sampled high on a rising
  // edge, then drops the following cycle; an ack without a request is ignored.

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic [DW-1:0]   dmem_addr_q, dmem_addr_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            retire_q, retire_d;
  logic [PC_W-1:0] pc_inc;
  logic            illegal;
  logic            br_taken;

  assign pc_inc   = pc_q + PC_W'(1);
  assign illegal  = (i_op > 4'd4);
  assign br_taken = i_bq_blt ? (i_src_val == i_dst_val)
                             : ($signed(i_src_val) < $signed(i_dst_val));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    dmem_addr_d = dmem_addr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    retire_d    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && i_imem_ack) begin
          ir_d    = i_imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (illegal) begin
`ifdef CORE_SEQ_TRAP_EN
          state_d = ST_HALT;
`else
          pc_d     = pc_inc;
          retire_d = 1'b1;
`endif
        end else if (i_lw) begin
          dmem_addr_d = i_src_val;
          waddr_d     = i_dst;
          state_d     = ST_MEM;
        end else if (i_j) begin
          pc_d     = i_imm[PC_W-1:0];
          retire_d = 1'b1;
        end else if (i_br) begin
          pc_d     = br_taken ? i_tgt_val[PC_W-1:0] : pc_inc;
          retire_d = 1'b1;
        end else begin
          we_d     = 1'b1;
          waddr_d  = i_dst;
          wdata_d  = i_src_val;
          pc_d     = pc_inc;
          retire_d = 1'b1;
        end
      end
      ST_MEM: begin
        if (dmem_req_q && i_dmem_ack) begin
          we_d     = 1'b1;
          wdata_d  = i_dmem_data;
          pc_d     = pc_inc;
          retire_d = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Requests are registered copies of "next state is FETCH/MEM", so they rise
  // one cycle after reset and fall the cycle after their ack.
  assign imem_req_d = (state_d == ST_FETCH);
  assign dmem_req_d = (state_d == ST_MEM);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_addr_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      retire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_addr_q <= dmem_addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      retire_q    <= retire_d;
    end
  end

`ifdef CORE_SEQ_TRAP_EN
  logic trap_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      trap_q <= 1'b0;
    end else if (state_d == ST_HALT) begin
      trap_q <= 1'b1;
    end
  end

  assign o_trap = trap_q;
`else
  assign o_trap = 1'b0;
`endif

  assign o_imem_req  = imem_req_q;
  assign o_pc        = pc_q;
  assign o_ir        = ir_q;
  assign o_dmem_req  = dmem_req_q;
  assign o_dmem_addr = dmem_addr_q;
  assign o_rf_we     = we_q;
  assign o_rf_waddr  = waddr_q;
  assign o_rf_wdata  = wdata_q;
  assign o_retire    = retire_q;
  assign o_dbg_state = state_q;

  // Source index and the upper immediate/target bits are not needed here.
  logic unused_ok;
  assign unused_ok = ^{i_src, i_imm[15:PC_W], i_tgt_val[DW-1:PC_W]};

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: directed instructions, expected writes/retires queued and
// checked by a monitor. Honors CORE_SEQ_TRAP_EN for the illegal-opcode case.
module tb_core_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [11:0] o_pc;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_ir;
  logic [3:0]  i_op;
  logic        i_lw, i_j, i_br, i_bq_blt;
  logic [4:0]  src_idx, dst_idx;
  logic [15:0] imm, src_val, dst_val, tgt_val;
  logic        o_dmem_req;
  logic [15:0] o_dmem_addr;
  logic        i_dmem_ack;
  logic [15:0] i_dmem_data;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [15:0] o_rf_wdata;
  logic        o_retire;
  logic        o_trap;
  logic [2:0]  o_dbg_state;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic [11:0] exp_pc;
  logic [20:0] exp_q[$];
  logic [11:0] exp_pc_q[$];

  // Clock / reset block
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Minimal decoder: opcode sits in ir[3:0], register fields come from bench variables.
  assign i_op     = o_ir[3:0];
  assign i_lw     = (i_op == 4'd1);
  assign i_j      = (i_op == 4'd2);
  assign i_br     = (i_op == 4'd3) || (i_op == 4'd4);
  assign i_bq_blt = (i_op == 4'd3);

  core_seq #(.PC_W(12), .DW(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_pc(o_pc), .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .o_ir(o_ir), .i_op(i_op), .i_lw(i_lw), .i_j(i_j), .i_br(i_br), .i_bq_blt(i_bq_blt),
    .i_src(src_idx), .i_dst(dst_idx), .i_imm(imm),
    .i_src_val(src_val), .i_dst_val(dst_val), .i_tgt_val(tgt_val),
    .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr), .i_dmem_ack(i_dmem_ack), .i_dmem_data(i_dmem_data),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_retire(o_retire), .o_trap(o_trap), .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},        32'(o_pc), 0);
    check({tag, "_ir"},        32'(o_ir), 0);
    check({tag, "_imem_req"},  32'(o_imem_req), 0);
    check({tag, "_dmem_req"},  32'(o_dmem_req), 0);
    check({tag, "_dmem_addr"}, 32'(o_dmem_addr), 0);
    check({tag, "_rf_we"},     32'(o_rf_we), 0);
    check({tag, "_rf_waddr"},  32'(o_rf_waddr), 0);
    check({tag, "_rf_wdata"},  32'(o_rf_wdata), 0);
    check({tag, "_retire"},    32'(o_retire), 0);
    check({tag, "_trap"},      32'(o_trap), 0);
    check({tag, "_state"},     32'(o_dbg_state), 0);
  endtask

  task automatic wait_imem_req();
    int guard = 0;
    while (!o_imem_req && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    check("imem_req_seen", 32'(o_imem_req), 1);
  endtask

  task automatic wait_dmem_req();
    int guard = 0;
    while (!o_dmem_req && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    check("dmem_req_seen", 32'(o_dmem_req), 1);
  endtask

  // Driver: serve one fetch (after iw wait cycles), optionally one data read
  // (after dw wait cycles), and queue the expected write / next PC.
  task automatic run_instr(input logic [15:0] instr, input int iw, input int dw,
                           input logic [15:0] ddata, input logic wr, input logic [4:0] waddr,
                           input logic [15:0] wdata, input logic [11:0] npc, input int ncyc);
    int t0;
    int guard;
    logic [3:0] op;
    op = instr[3:0];
    wait_imem_req();
    if (!o_imem_req) return;
    check("fetch_pc", 32'(o_pc), 32'(exp_pc));
    if (wr) exp_q.push_back({waddr, wdata});
    exp_pc_q.push_back(npc);
    t0 = cyc;
    repeat (iw) @(negedge i_clk);
    check("pc_stable_in_fetch", 32'(o_pc), 32'(exp_pc));
    i_imem_ack = 1'b1;
    i_imem_data = instr;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    check("ir_loaded", 32'(o_ir), 32'(instr));
    check("imem_req_dropped", 32'(o_imem_req), 0);
    if (op == 4'd1) begin
      wait_dmem_req();
      for (int k = 0; k <= dw; k++) begin
        if (k > 0) @(negedge i_clk);
        check("dmem_addr_hold", 32'(o_dmem_addr), 32'(src_val));
        check("no_concurrent_req", 32'(o_imem_req), 0);
      end
      i_dmem_ack = 1'b1;
      i_dmem_data = ddata;
      @(negedge i_clk);
      i_dmem_ack = 1'b0;
    end
    guard = 0;
    while (!o_retire && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    check("retire_seen", 32'(o_retire), 1);
    check("instr_cycles", 32'(cyc - t0), 32'(ncyc));
    exp_pc = npc;
  endtask

  task automatic set_regs(input logic [4:0] d, input logic [15:0] s_v, input logic [15:0] d_v,
                          input logic [15:0] t_v, input logic [15:0] im);
    src_idx = 5'd1;
    dst_idx = d;
    src_val = s_v;
    dst_val = d_v;
    tgt_val = t_v;
    imm = im;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT writes or retires.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_rf_we) begin
        if (exp_q.size() == 0) check("unexpected_rf_we", 1, 0);
        else check("rf_write", 32'({o_rf_waddr, o_rf_wdata}), 32'(exp_q.pop_front()));
      end
      if (o_retire) begin
        if (exp_pc_q.size() == 0) check("unexpected_retire", 1, 0);
        else check("retire_pc", 32'(o_pc), 32'(exp_pc_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    i_rst = 1'b1;
    i_imem_ack = 1'b0;
    i_imem_data = '0;
    i_dmem_ack = 1'b0;
    i_dmem_data = '0;
    set_regs(5'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_pc = 12'h000;
    repeat (3) @(negedge i_clk);
    check_reset("rst");
    i_rst = 1'b0;

    // mov R3 <- 0x1234 at PC 0, zero-wait
    set_regs(5'd3, 16'h1234, 16'h0, 16'h0, 16'h0);
    run_instr(16'h0310, 0, 0, 16'h0, 1'b1, 5'd3, 16'h1234, 12'h001, 3);
    // lw R7 <- [0x0040], dmem two wait cycles
    set_regs(5'd7, 16'h0040, 16'h0, 16'h0, 16'h0);
    run_instr(16'h0711, 0, 2, 16'hBEEF, 1'b1, 5'd7, 16'hBEEF, 12'h002, 6);
    // blt -1 < 1 taken to R31
    set_regs(5'd2, 16'hFFFF, 16'h0001, 16'h0200, 16'h0);
    run_instr(16'h0024, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h200, 3);
    // beq same values: not taken
    run_instr(16'h0023, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h201, 3);
    // beq equal values: taken, target truncated to 12 bits
    set_regs(5'd2, 16'h0077, 16'h0077, 16'h7030, 16'h0);
    run_instr(16'h0023, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h030, 3);
    // blt 1 < -1 is false: not taken
    set_regs(5'd2, 16'h0001, 16'hFFFF, 16'h0400, 16'h0);
    run_instr(16'h0024, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h031, 3);
    // mov R31 with two imem wait cycles
    set_regs(5'd31, 16'h00A5, 16'h0, 16'h0, 16'h0);
    run_instr(16'h1F10, 2, 0, 16'h0, 1'b1, 5'd31, 16'h00A5, 12'h032, 5);
    // j to 0xFFF, then j with upper imm bits set to 0x005
    set_regs(5'd0, 16'h0, 16'h0, 16'h0, 16'h0FFF);
    run_instr(16'h0002, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'hFFF, 3);
    set_regs(5'd0, 16'h0, 16'h0, 16'h0, 16'hA005);
    run_instr(16'h0002, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h005, 3);
    set_regs(5'd0, 16'h0, 16'h0, 16'h0, 16'h0FFF);
    run_instr(16'h0002, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'hFFF, 3);
    // mov at 0xFFF: PC wraps to 0
    set_regs(5'd0, 16'h5555, 16'h0, 16'h0, 16'h0);
    run_instr(16'h0010, 0, 0, 16'h0, 1'b1, 5'd0, 16'h5555, 12'h000, 3);

    // Illegal opcode 0x9
`ifdef CORE_SEQ_TRAP_EN
    wait_imem_req();
    check("trap_fetch_pc", 32'(o_pc), 32'(exp_pc));
    i_imem_ack = 1'b1;
    i_imem_data = 16'h0009;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    check("trap_set", 32'(o_trap), 1);
    check("halt_state", 32'(o_dbg_state), 32'd4);
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_imem_req || o_dmem_req || o_pc != exp_pc || !o_trap) bad++;
    end
    check("halt_quiet_cycles_bad", 32'(bad), 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("trap_cleared", 32'(o_trap), 0);
    exp_pc = 12'h000;
`else
    bad = 0;
    run_instr(16'h0009, 0, 0, 16'h0, 1'b0, 5'd0, 16'h0, 12'h001, 3);
    check("trap_tied_low", 32'(o_trap), 0);
`endif

    // Reset during a lw data wait; the late ack must be ignored
    set_regs(5'd9, 16'h0080, 16'h0, 16'h0, 16'h0);
    wait_imem_req();
    check("rst_test_fetch_pc", 32'(o_pc), 32'(exp_pc));
    i_imem_ack = 1'b1;
    i_imem_data = 16'h0911;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    wait_dmem_req();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset("mid_rst");
    i_rst = 1'b0;
    i_dmem_ack = 1'b1;
    i_dmem_data = 16'hDEAD;
    @(negedge i_clk);
    i_dmem_ack = 1'b0;
    check("restart_imem_req", 32'(o_imem_req), 1);
    check("late_ack_no_write", 32'(o_rf_we), 0);
    check("restart_pc", 32'(o_pc), 0);
    exp_pc = 12'h000;

    // Normal operation resumes after reset
    set_regs(5'd12, 16'hCAFE, 16'h0, 16'h0, 16'h0);
    run_instr(16'h0C10, 0, 0, 16'h0, 1'b1, 5'd12, 16'hCAFE, 12'h001, 3);

    repeat (3) @(negedge i_clk);
    check("write_queue_drained", 32'(exp_q.size()), 0);
    check("retire_queue_drained", 32'(exp_pc_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle sequencer for the g_core 16-bit processor. It fetches instructions over a req/ack instruction-memory port and drives the instruction register into the decoder. From the decoded flags it steps through execute, data-memory and write-back, and owns the PC, register-file write port and data-memory request. The decoder is purely combinational; core_seq is the only stateful control element in the core.

## Interface
- PC_W, 12: PC and instruction-memory address width; jump target is i_imm[PC_W-1:0].
- DW, 16: register/data width.

- i_clk  in  1  core clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_imem_req  out  1  instruction fetch request
- o_pc  out  PC_W  current PC, fetch address
- i_imem_ack  in  1  fetch data valid
- i_imem_data  in  16  fetched instruction
- o_ir  out  16  instruction register, drives decoder i_instr
- i_op  in  4  o_ir[3:0], for illegal-opcode detection
- i_lw, i_j, i_br, i_bq_blt  in  1 each  decoder flags
- i_src, i_dst  in  5 each  decoder register fields
- i_imm  in  16  decoder immediate
- i_src_val, i_dst_val, i_tgt_val  in  DW each  register-file reads of R[src], R[dst], R31
- o_dmem_req  out  1  data read request
- o_dmem_addr  out  DW  data address, = R[src] latched in EXEC
- i_dmem_ack, i_dmem_data  in  1, DW  read data valid and value
- o_rf_we  out  1  register write strobe
- o_rf_waddr  out  5  write address
- o_rf_wdata  out  DW  write data
- o_retire  out  1  one-cycle pulse per completed instruction
- o_trap  out  1  illegal-opcode halt indicator

## Operation
- Reset values: state FETCH, o_pc 0, o_ir 0, o_imem_req 0, o_dmem_req 0, o_dmem_addr 0, o_rf_we 0, o_rf_waddr 0, o_rf_wdata 0, o_retire 0, o_trap 0.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH: o_imem_req=1 with o_pc stable. On i_imem_ack, o_ir<=i_imem_data, req drops next cycle, go DECODE.
- DECODE: one cycle. Decoder outputs and register reads settle; go EXEC.
- EXEC, by op:
  - mov (op 0): o_rf_we pulse, waddr=i_dst, wdata=i_src_val; PC+1; retire; go FETCH.
  - lw (op 1): latch o_dmem_addr=i_src_val, waddr=i_dst; go MEM.
  - j (op 2): PC<=i_imm[PC_W-1:0]; retire; go FETCH.
  - beq (i_br & i_bq_blt): taken if i_src_val==i_dst_val.
  - blt (i_br & ~i_bq_blt): taken if $signed(i_src_val) < $signed(i_dst_val).
  - Branch PC: taken -> i_tgt_val[PC_W-1:0], else PC+1; retire; go FETCH.
- MEM: o_dmem_req=1, address stable. On i_dmem_ack: o_rf_we pulse with wdata=i_dmem_data; PC+1; retire; go FETCH.
- PC+1 wraps modulo 2^PC_W (max -> 0).
- Opcodes 5-15: see Configuration.
- Acks with no request outstanding are ignored.
- Reset mid-operation: every state returns to reset values on the next edge. Outstanding requests are abandoned and a late ack is ignored.

## Timing
- Request held high until ack is sampled high; ack in the same cycle as req rising is legal. Req is low the cycle after ack.
- Zero-wait memories: mov/j/branch take 3 cycles (FETCH, DECODE, EXEC); lw takes 4. Each imem/dmem wait cycle adds one.
- o_rf_we and o_retire are single-cycle, registered, asserted the cycle after the completing edge condition. New PC is visible on o_pc in the next FETCH.
- At most one request of either kind outstanding; imem and dmem requests are never concurrent.

## Configuration
- CORE_SEQ_TRAP_EN defined: op 5-15 in EXEC -> HALT. o_trap=1, no write, PC frozen at the offending address, all requests low until i_rst.
- Undefined: op 5-15 execute as NOP, meaning PC+1, retire, no write. o_trap is tied 0 and HALT is unreachable.

## Test plan
- mov with zero-wait imem, R[src]=0x1234, dst=3: o_rf_we once with waddr 3, wdata 0x1234, 3 cycles from req, o_pc 0 -> 1.
- lw with dmem ack delayed 2 cycles, R[src]=0x0040, data 0xBEEF, dst=7: dmem_addr 0x0040 held for 3 cycles, single write to R7 = 0xBEEF, 6 cycles total.
- blt with src=0xFFFF, dst=0x0001, R31=0x0200: taken, o_pc=0x200. beq with the same values: not taken, o_pc+1. j at PC 0xFFF with imm 0x005: o_pc=0x005. Then mov at 0xFFF: o_pc wraps to 0.
- Op 0x9: with CORE_SEQ_TRAP_EN, o_trap=1, o_pc frozen, no req for 20 cycles. Without it, retire with no write and o_pc+1.
- i_rst asserted during MEM wait, ack arriving the cycle after: no write, o_pc=0, FETCH request restarts the cycle after reset deasserts.
